// File: rtl/i2c_pkg.sv
// Shared constants and FSM encoding for the I2C master arbiter.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: searches from last_grant+1 (mod NUM_REQ) for the first active request.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  logic [IDX_W-1:0] sel;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    sel   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      sel = IDX_W'((32'(last_grant) + i) % NUM_REQ);
      if (!valid && req[sel]) begin
        grant[sel] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arb.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ requesters.
// Optional watchdog enabled by defining I2C_MASTER_ARB_TIMEOUT_EN.
module i2c_master_arb
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WR_BITS     = 1,
  parameter int unsigned RD_BITS     = 1,
  parameter int unsigned TIMEOUT_CYC = 32'd1_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ-1:0]            i_req_rh_wl,
  input  logic [NUM_REQ-1:0]            i_req_bit_ctrl,
  input  logic [NUM_REQ*I2C_ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*WR_BITS*8-1:0]  i_req_wdata,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [RD_BITS*8-1:0]          o_rsp_rdata,
  output logic                          o_rsp_ack,
  output logic                          o_rsp_timeout,
  output logic                          o_i2c_wvalid,
  input  logic                          i_i2c_wready,
  output logic                          o_cmd_bit_ctrl,
  output logic                          o_cmd_rh_wl,
  output logic [I2C_ADDR_W-1:0]         o_i2c_addr,
  output logic [WR_BITS*8-1:0]          o_i2c_wdata,
  input  logic [RD_BITS*8-1:0]          i_i2c_rdata,
  input  logic                          i_i2c_rvalid,
  input  logic                          i_i2c_done,
  input  logic                          i_i2c_ack,
  input  logic                          i_i2c_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W  = WR_BITS * 8;
  localparam int unsigned RD_W  = RD_BITS * 8;

  arb_state_e state_q, state_d;

  logic [NUM_REQ-1:0]    arb_grant, grant_q;
  logic                  arb_valid, take, in_txn, wd_hit, rsp_to;
  logic [IDX_W-1:0]      grant_idx, idx_q, last_q;
  logic                  rh_wl_q, bit_ctrl_q, ack_q;
  logic [I2C_ADDR_W-1:0] addr_q;
  logic [WD_W-1:0]       wdata_q;
  logic [RD_W-1:0]       rdata_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req        (i_req_valid),
    .last_grant (last_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) grant_idx = IDX_W'(i);
    end
  end

  assign take   = (state_q == StIdle) && !i_i2c_busy && arb_valid;
  assign in_txn = (state_q == StIssue) || (state_q == StWait);

`ifdef I2C_MASTER_ARB_TIMEOUT_EN
  logic [31:0] wd_q;
  logic        timeout_q;

  assign wd_hit = in_txn && (wd_q == 32'(TIMEOUT_CYC - 1));
  assign rsp_to = timeout_q;

  // A done arriving on the expiry cycle still counts as a real completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (take) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (in_txn) begin
      wd_q <= wd_q + 32'd1;
      if (wd_hit && !((state_q == StWait) && i_i2c_done)) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign rsp_to = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (take) state_d = StIssue;
      StIssue: begin
        if (wd_hit)            state_d = StResp;
        else if (i_i2c_wready) state_d = StWait;
      end
      StWait:  if (i_i2c_done || wd_hit) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Ready is gated by rst_n so it drops at once while reset is held.
  always_comb begin
    o_req_ready   = (rst_n && take) ? arb_grant : '0;
    o_i2c_wvalid  = (state_q == StIssue);
    o_rsp_valid   = (state_q == StResp) ? grant_q : '0;
    o_rsp_rdata   = ((state_q == StResp) && !rsp_to) ? rdata_q : '0;
    o_rsp_ack     = (state_q == StResp) && ack_q && !rsp_to;
    o_rsp_timeout = (state_q == StResp) && rsp_to;
  end

  assign o_cmd_rh_wl    = rh_wl_q;
  assign o_cmd_bit_ctrl = bit_ctrl_q;
  assign o_i2c_addr     = addr_q;
  assign o_i2c_wdata    = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q    <= '0;
      idx_q      <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      rh_wl_q    <= 1'b0;
      bit_ctrl_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
    end else begin
      if (take) begin
        grant_q    <= arb_grant;
        idx_q      <= grant_idx;
        rh_wl_q    <= i_req_rh_wl[grant_idx];
        bit_ctrl_q <= i_req_bit_ctrl[grant_idx];
        addr_q     <= i_req_addr[int'(grant_idx)*I2C_ADDR_W +: I2C_ADDR_W];
        wdata_q    <= i_req_wdata[int'(grant_idx)*WD_W +: WD_W];
        rdata_q    <= '0;
        ack_q      <= 1'b0;
      end
      // Write commands never capture read data, so their response data stays zero.
      if (state_q == StWait) begin
        if (i_i2c_rvalid && rh_wl_q) rdata_q <= i_i2c_rdata;
        if (i_i2c_done)              ack_q   <= i_i2c_ack;
      end
      if (state_q == StResp) last_q <= idx_q;
    end
  end

endmodule

// File: tb/tb_i2c_master_arb.sv
// Self-checking bench for i2c_master_arb: directed scenarios plus randomized traffic
// against a transaction-level model. Define I2C_MASTER_ARB_TIMEOUT_EN to cover the watchdog.
module tb_i2c_master_arb;

  localparam int NR = 4;
`ifdef I2C_MASTER_ARB_TIMEOUT_EN
  localparam int unsigned TO    = 100;
  localparam bit          TO_EN = 1'b1;
`else
  localparam int unsigned TO    = 1_000_000;
  localparam bit          TO_EN = 1'b0;
`endif

  logic        clk, rst_n;
  logic [3:0]  r_valid, r_rh, r_bc;
  logic [15:0] r_addr [NR];
  logic [7:0]  r_wd   [NR];
  logic [63:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [3:0]  o_req_ready, o_rsp_valid;
  logic [7:0]  o_rsp_rdata, o_i2c_wdata, i_i2c_rdata;
  logic        o_rsp_ack, o_rsp_timeout, o_i2c_wvalid, o_cmd_bit_ctrl, o_cmd_rh_wl;
  logic [15:0] o_i2c_addr;
  logic        i_i2c_wready, i_i2c_rvalid, i_i2c_done, i_i2c_ack, i_i2c_busy;

  assign i_req_addr  = {r_addr[3], r_addr[2], r_addr[1], r_addr[0]};
  assign i_req_wdata = {r_wd[3], r_wd[2], r_wd[1], r_wd[0]};

  i2c_master_arb #(
    .NUM_REQ     (NR),
    .WR_BITS     (1),
    .RD_BITS     (1),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (r_valid),
    .o_req_ready    (o_req_ready),
    .i_req_rh_wl    (r_rh),
    .i_req_bit_ctrl (r_bc),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_rdata    (o_rsp_rdata),
    .o_rsp_ack      (o_rsp_ack),
    .o_rsp_timeout  (o_rsp_timeout),
    .o_i2c_wvalid   (o_i2c_wvalid),
    .i_i2c_wready   (i_i2c_wready),
    .o_cmd_bit_ctrl (o_cmd_bit_ctrl),
    .o_cmd_rh_wl    (o_cmd_rh_wl),
    .o_i2c_addr     (o_i2c_addr),
    .o_i2c_wdata    (o_i2c_wdata),
    .i_i2c_rdata    (i_i2c_rdata),
    .i_i2c_rvalid   (i_i2c_rvalid),
    .i_i2c_done     (i_i2c_done),
    .i_i2c_ack      (i_i2c_ack),
    .i_i2c_busy     (i_i2c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, errors;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_ack, o_rsp_timeout, o_i2c_wvalid,
                o_cmd_bit_ctrl, o_cmd_rh_wl, o_i2c_addr, o_i2c_wdata});
  endfunction

  // Transaction-level model: who owns the master, whether the command is still
  // awaiting acceptance, and whether a response is due this cycle.
  int          owner, last, wd;
  bit          cmd_pend, rsp_now, m_rh, m_bc, m_to, m_ack;
  logic [15:0] m_addr;
  logic [7:0]  m_wd, m_rd;
  logic [3:0]  ready_seen;

  always @(negedge clk) begin : compare
    int         g;
    logic [3:0] er, ev;
    ready_seen = o_req_ready;
    if (!rst_n) begin
      chk("reset_outputs", all_outs(), 64'd0);
      owner = -1; cmd_pend = 0; rsp_now = 0; last = NR - 1; m_to = 0;
    end else begin
      g = -1;
      if (owner < 0 && !i_i2c_busy) begin
        for (int k = 1; k <= NR; k++) begin
          if (g < 0 && r_valid[(last + k) % NR]) g = (last + k) % NR;
        end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      ev = '0;
      if (rsp_now) ev[owner] = 1'b1;
      chk("ready", 64'(o_req_ready), 64'(er));
      chk("wvalid", 64'(o_i2c_wvalid), 64'(owner >= 0 && cmd_pend));
      if (owner >= 0 && cmd_pend)
        chk("cmd_fields", 64'({o_cmd_rh_wl, o_cmd_bit_ctrl, o_i2c_addr, o_i2c_wdata}),
            64'({m_rh, m_bc, m_addr, m_wd}));
      chk("rsp_valid", 64'(o_rsp_valid), 64'(ev));
      chk("rsp_timeout", 64'(o_rsp_timeout), 64'(rsp_now && m_to));
      if (rsp_now) begin
        chk("rsp_rdata", 64'(o_rsp_rdata), 64'(m_to ? 8'h00 : m_rd));
        chk("rsp_ack", 64'(o_rsp_ack), 64'(m_ack && !m_to));
      end
      if (rsp_now) begin
        last = owner; owner = -1; rsp_now = 0;
      end else if (g >= 0) begin
        owner = g; cmd_pend = 1; m_rd = '0; m_ack = 0; m_to = 0; wd = 0;
        m_rh = r_rh[g]; m_bc = r_bc[g]; m_addr = r_addr[g]; m_wd = r_wd[g];
      end else if (owner >= 0) begin
        wd++;
        if (cmd_pend) begin
          if (i_i2c_wready) cmd_pend = 0;
        end else begin
          if (i_i2c_rvalid && m_rh) m_rd = i_i2c_rdata;
          if (i_i2c_done) begin
            m_ack = i_i2c_ack; rsp_now = 1;
          end
        end
        if (TO_EN && !rsp_now && wd == int'(TO)) begin
          rsp_now = 1; m_to = 1; cmd_pend = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit rh, input bit bc, input logic [15:0] a,
                         input logic [7:0] d);
    r_valid[i] = 1'b1; r_rh[i] = rh; r_bc[i] = bc; r_addr[i] = a; r_wd[i] = d;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, acc;
    int got [8];
    checks = 0; errors = 0;
    rst_n = 1'b0; r_valid = '1; r_rh = '0; r_bc = '0;
    for (int i = 0; i < NR; i++) begin
      r_addr[i] = '0; r_wd[i] = '0;
    end
    i_i2c_wready = 0; i_i2c_rvalid = 0; i_i2c_done = 0; i_i2c_ack = 0; i_i2c_busy = 0;
    i_i2c_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready_held_low", 64'(o_req_ready), 64'd0);
    tick();
    r_valid = '0; rst_n = 1'b1;

    // Single read from requester 2.
    tick();
    set_req(2, 1'b1, 1'b0, 16'h0010, 8'h00);
    i_i2c_wready = 1;
    @(negedge clk) chk("read_grant", 64'(o_req_ready), 64'h4);
    tick(); r_valid[2] = 0;
    tick(); i_i2c_rvalid = 1; i_i2c_rdata = 8'hA5; i_i2c_done = 1; i_i2c_ack = 1;
    tick(); i_i2c_rvalid = 0; i_i2c_done = 0; i_i2c_ack = 0;
    @(negedge clk);
    chk("read_rsp_valid", 64'(o_rsp_valid), 64'h4);
    chk("read_rdata", 64'(o_rsp_rdata), 64'hA5);
    chk("read_ack", 64'(o_rsp_ack), 64'h1);

    // Write with wready held low for 10 cycles.
    tick();
    set_req(1, 1'b0, 1'b1, 16'h1234, 8'h5A);
    i_i2c_wready = 0;
    @(negedge clk) chk("bp_grant", 64'(o_req_ready), 64'h2);
    tick(); r_valid[1] = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_wvalid", 64'(o_i2c_wvalid), 64'h1);
      chk("bp_addr", 64'(o_i2c_addr), 64'h1234);
      tick();
    end
    i_i2c_wready = 1;
    @(negedge clk) chk("bp_wvalid_accept", 64'(o_i2c_wvalid), 64'h1);
    tick(); i_i2c_wready = 0; i_i2c_done = 1;
    @(negedge clk) chk("bp_wait_wvalid", 64'(o_i2c_wvalid), 64'h0);
    tick(); i_i2c_done = 0;
    @(negedge clk);
    chk("wr_rsp_valid", 64'(o_rsp_valid), 64'h2);
    chk("wr_rdata_zero", 64'(o_rsp_rdata), 64'h0);

    // Busy gating.
    tick();
    i_i2c_busy = 1; set_req(0, 1'b0, 1'b0, 16'h0042, 8'h11);
    repeat (5) begin
      @(negedge clk) chk("busy_no_ready", 64'(o_req_ready), 64'h0);
      tick();
    end
    i_i2c_busy = 0;
    @(negedge clk) chk("busy_release_grant", 64'(o_req_ready), 64'h1);
    tick(); r_valid[0] = 0; i_i2c_wready = 1; i_i2c_done = 1; i_i2c_ack = 1;
    repeat (4) tick();
    i_i2c_done = 0; i_i2c_ack = 0;

    // Reset while waiting for done.
    set_req(3, 1'b1, 1'b0, 16'h0777, 8'h00);
    @(negedge clk) chk("rstmid_grant", 64'(o_req_ready), 64'h8);
    tick(); r_valid[3] = 0;
    tick();
    tick();
    rst_n = 0;
    @(negedge clk) chk("rstmid_outputs", all_outs(), 64'd0);
    tick(); rst_n = 1;
    repeat (5) begin
      @(negedge clk) chk("rstmid_no_rsp", 64'(o_rsp_valid), 64'h0);
      tick();
    end

    // Fairness with all requesters continuously valid.
    for (int i = 0; i < NR; i++) rand_req(i);
    i_i2c_wready = 1; i_i2c_done = 1; i_i2c_ack = 1; i_i2c_rvalid = 1; i_i2c_rdata = 8'h3C;
    n = 0;
    for (int cyc = 0; cyc < 200 && n < 8; cyc++) begin
      @(negedge clk);
      acc = -1;
      for (int i = 0; i < NR; i++) if (o_req_ready[i]) acc = i;
      if (acc >= 0) begin
        got[n] = acc; n++;
      end
      tick();
      if (acc >= 0) rand_req(acc);
    end
    chk("fair_count", 64'(n), 64'd8);
    for (int k = 0; k < 8; k++) if (k < n) chk("fair_order", 64'(got[k]), 64'(k % 4));
    r_valid = '0;
    repeat (6) tick();
    i_i2c_done = 0; i_i2c_rvalid = 0; i_i2c_ack = 0;

`ifdef I2C_MASTER_ARB_TIMEOUT_EN
    set_req(1, 1'b1, 1'b0, 16'h00AB, 8'h00);
    i_i2c_wready = 1;
    @(negedge clk) chk("to_grant", 64'(o_req_ready), 64'h2);
    tick(); r_valid[1] = 0;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (o_rsp_timeout) break;
      n++;
      tick();
    end
    chk("to_latency", 64'(n), 64'd100);
    chk("to_rsp_valid", 64'(o_rsp_valid), 64'h2);
    chk("to_ack", 64'(o_rsp_ack), 64'h0);
    chk("to_rdata", 64'(o_rsp_rdata), 64'h0);
    tick();
    @(negedge clk) chk("to_idle", 64'({o_rsp_valid, o_rsp_timeout, o_i2c_wvalid}), 64'h0);
    i_i2c_wready = 0;
`endif

    // Randomized traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (ready_seen[i]) begin
          if ($urandom % 2 == 0) rand_req(i);
          else r_valid[i] = 1'b0;
        end else if (r_valid[i]) begin
          if ($urandom % 16 == 0) r_valid[i] = 1'b0;
        end else if ($urandom % 3 == 0) begin
          rand_req(i);
        end
      end
      i_i2c_wready = ($urandom % 2 == 0);
      i_i2c_rvalid = ($urandom % 3 == 0);
      i_i2c_rdata  = 8'($urandom);
      i_i2c_done   = ($urandom % 4 == 0);
      i_i2c_ack    = 1'($urandom);
      i_i2c_busy   = ($urandom % 8 == 0);
      rst_n        = (cyc % 997 != 500);
    end
    tick();
    rst_n = 1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_arb.md
I2C_MASTER_ARB -- requirements
Module: i2c_master_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one i2c_master_module (range 2..8).
REQ-002 The block SHALL have parameter WR_BITS, default 1, giving the write payload width in bytes.
REQ-003 The block SHALL have parameter RD_BITS, default 1, giving the read payload width in bytes.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 32'd1_000_000, giving the watchdog limit in clk cycles.
REQ-005 The block SHALL have one clock and one reset: clk, input, 1, the single clock; rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 Requester ports: i_req_valid in NUM_REQ; o_req_ready out NUM_REQ; i_req_rh_wl in NUM_REQ (1 = read); i_req_bit_ctrl in NUM_REQ; i_req_addr in NUM_REQ*16; i_req_wdata in NUM_REQ*WR_BITS*8; all packed with requester 0 in the LSBs.
REQ-007 Response ports: o_rsp_valid out NUM_REQ (one-hot); o_rsp_rdata out RD_BITS*8; o_rsp_ack out 1; o_rsp_timeout out 1.
REQ-008 Master-side ports: o_i2c_wvalid out 1; i_i2c_wready in 1; o_cmd_bit_ctrl out 1; o_cmd_rh_wl out 1; o_i2c_addr out 16; o_i2c_wdata out WR_BITS*8; i_i2c_rdata in RD_BITS*8; i_i2c_rvalid in 1; i_i2c_done in 1; i_i2c_ack in 1; i_i2c_busy in 1.

Function
REQ-009 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, in that order per transaction.
REQ-010 In IDLE, with i_i2c_busy low and any i_req_valid high, the block SHALL grant round-robin, starting at last_grant+1 modulo NUM_REQ.
REQ-011 On the grant cycle, the block SHALL pulse o_req_ready[grant] for one cycle, latch that requester's rh_wl, bit_ctrl, addr and wdata, and go to ISSUE.
REQ-012 o_req_ready SHALL be high only in IDLE and only for the granted index; a requester SHALL hold its fields until accepted.
REQ-013 In ISSUE, o_i2c_wvalid SHALL be 1 with latched fields stable until i_i2c_wready is sampled high; the block SHALL then move to WAIT with o_i2c_wvalid low.
REQ-014 In WAIT, the block SHALL capture i_i2c_rdata on i_i2c_rvalid and i_i2c_ack on i_i2c_done; done moves the FSM to RESP; rvalid and done in the same cycle both take effect.
REQ-015 In RESP, for one cycle, the block SHALL assert o_rsp_valid[grant] with o_rsp_rdata and o_rsp_ack, update last_grant, and return to IDLE.
REQ-016 For write commands, o_rsp_rdata SHALL be all-zero.
REQ-017 Minimum latency from accept to o_rsp_valid SHALL be 3 cycles plus the master's wready and done latency; back-to-back grants SHALL have at least one IDLE cycle between them.
REQ-018 A requester deasserting i_req_valid before its grant SHALL NOT be granted.

Reset
REQ-019 On rst_n low, the block SHALL immediately clear all outputs to 0, set the state to IDLE, set last_grant to NUM_REQ-1 so requester 0 is first, and clear the watchdog counter.
REQ-020 A reset during ISSUE or WAIT SHALL abandon the transaction and SHALL NOT emit any response.

Configuration
REQ-021 With macro I2C_MASTER_ARB_TIMEOUT_EN defined, a counter SHALL run in ISSUE and WAIT, and on reaching TIMEOUT_CYC the block SHALL go to RESP with o_rsp_timeout=1, o_rsp_ack=0 and o_rsp_rdata=0.
REQ-022 Without I2C_MASTER_ARB_TIMEOUT_EN, no counter SHALL exist and o_rsp_timeout SHALL be tied to 0, with the port kept.

Structure
REQ-023 State encodings and the I2C_ADDR_W=16 constant SHALL reside in shared package i2c_pkg.
REQ-024 Round-robin selection SHALL be a sub-module rr_arbiter taking NUM_REQ, req and last_grant and producing a one-hot grant plus a valid flag.

Verification
REQ-025 Single read: req2 read, addr 16'h0010; model returns rdata 8'hA5, ack 1 -> o_rsp_valid=4'b0100, rdata 8'hA5, ack 1.
REQ-026 Fairness: all four requesters held valid continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-027 Backpressure: i_i2c_wready held low 10 cycles -> o_i2c_wvalid held high with o_i2c_addr stable for 10 cycles, then WAIT.
REQ-028 Busy gating: i_i2c_busy high while req0 is valid -> no o_req_ready until busy falls.
REQ-029 Timeout (macro defined, TIMEOUT_CYC=100): done never arrives -> o_rsp_timeout=1 exactly 100 cycles after ISSUE entry, then IDLE.
REQ-030 Reset mid-WAIT: rst_n pulsed low -> all outputs 0, no o_rsp_valid, next grant goes to requester 0.
